// File: rtl/chebyshev_series_eval.sv
// Chebyshev series evaluator: y = sum c_k*T_k(x), one term per clock, valid/ready I/O.
// Optional sat_out flag (any clamped T_k in the sample) is enabled by defining CHEB_SAT_FLAG_EN.
module chebyshev_series_eval #(
  parameter int WL       = 4,
  parameter int CL       = 4,
  parameter int CFL      = 2,
  parameter int ORDER    = 3,
  parameter int WIDENING = 0,
  localparam int TW      = WL + 2,
  localparam int AW      = (ORDER > 0) ? $clog2(ORDER + 1) : 1,
  localparam int NTW     = $clog2(ORDER + 1) + 1,
  localparam int ACCW    = CL + TW + $clog2(ORDER + 1) + WIDENING
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   coeff_we,
  input  logic [AW-1:0]          coeff_addr,
  input  logic signed [CL-1:0]   coeff_data,
  input  logic [NTW-1:0]         n_terms,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [WL-1:0]   x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] data_out
`ifdef CHEB_SAT_FLAG_EN
  ,
  output logic                   sat_out
`endif
);

  localparam int PW = WL + TW + 1;
  localparam int PRW = CL + TW;
  localparam logic signed [TW-1:0] T_ONE = TW'(2 ** (WL - 1));
  localparam logic signed [PW-1:0] T_HI = PW'(2 ** (TW - 1) - 1);
  localparam logic signed [PW-1:0] T_LO = PW'(-(2 ** (TW - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [CL-1:0]   coeff [ORDER+1];
  logic signed [WL-1:0]   x_q;
  logic [NTW-1:0]         n_q;
  logic [NTW-1:0]         k_q;
  logic signed [TW-1:0]   t_prev;
  logic signed [TW-1:0]   t_cur;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] data_q;

  logic signed [CL-1:0]   c_k;
  logic signed [PRW-1:0]  term;
  logic signed [ACCW-1:0] acc_next;
  logic signed [PW-1:0]   xt;
  logic signed [PW-1:0]   t_wide;
  logic signed [TW-1:0]   t_next;
  logic                   clamp;
  logic [NTW-1:0]         n_clamped;
  logic                   last;

  assign c_k       = coeff[k_q[AW-1:0]];
  assign term      = PRW'(c_k) * PRW'(t_cur);
  assign acc_next  = acc + ACCW'(term);
  assign xt        = PW'(x_q) * PW'(t_cur);
  assign t_wide    = ((xt >>> (WL - 1)) <<< 1) - PW'(t_prev);
  assign n_clamped = (n_terms > NTW'(ORDER)) ? NTW'(ORDER) : n_terms;
  assign last      = (k_q == n_q);

  always_comb begin
    clamp  = 1'b0;
    t_next = t_wide[TW-1:0];
    if (t_wide > T_HI) begin
      clamp  = 1'b1;
      t_next = T_HI[TW-1:0];
    end else if (t_wide < T_LO) begin
      clamp  = 1'b1;
      t_next = T_LO[TW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) state_d = ITER;
      end
      ITER: begin
        if (last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= ORDER; i++) coeff[i] <= '0;
      x_q    <= '0;
      n_q    <= '0;
      k_q    <= '0;
      t_prev <= '0;
      t_cur  <= '0;
      acc    <= '0;
      data_q <= '0;
    end else begin
      if (coeff_we && state_q == IDLE && {1'b0, coeff_addr} <= (AW + 1)'(ORDER))
        coeff[coeff_addr] <= coeff_data;
      if (state_q == IDLE && in_valid) begin
        x_q    <= x_in;
        n_q    <= n_clamped;
        k_q    <= '0;
        // Seeding T_prev with x (T_-1 = T_1) makes the first recurrence step yield T_1 = x.
        t_prev <= TW'(x_in);
        t_cur  <= T_ONE;
        acc    <= '0;
      end else if (state_q == ITER) begin
        acc    <= acc_next;
        t_prev <= t_cur;
        t_cur  <= t_next;
        k_q    <= k_q + 1'b1;
        if (last) data_q <= acc_next;
      end
    end
  end

  assign data_out = data_q;

`ifdef CHEB_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clock) begin
    if (reset)                               sat_q <= 1'b0;
    else if (state_q == IDLE && in_valid)    sat_q <= 1'b0;
    else if (state_q == ITER && clamp)       sat_q <= 1'b1;
  end

  assign sat_out = sat_q;
`endif

endmodule

// File: tb/tb_chebyshev_series_eval.sv
// Directed bench for chebyshev_series_eval (WL=4, CL=4, CFL=2, ORDER=3; y LSB = 1/32).
module tb_chebyshev_series_eval;

  logic              clock;
  logic              reset;
  logic              coeff_we;
  logic [1:0]        coeff_addr;
  logic signed [3:0] coeff_data;
  logic [2:0]        n_terms;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] x_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [11:0] data_out;
`ifdef CHEB_SAT_FLAG_EN
  logic              sat_out;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int seen;

  chebyshev_series_eval #(
    .WL(4), .CL(4), .CFL(2), .ORDER(3), .WIDENING(0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .n_terms    (n_terms),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out)
`ifdef CHEB_SAT_FLAG_EN
    ,
    .sat_out    (sat_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [1:0] a, input logic signed [3:0] d);
    coeff_we   = 1'b1;
    coeff_addr = a;
    coeff_data = d;
    tick();
    coeff_we   = 1'b0;
  endtask

  task automatic send(input string tag, input logic signed [3:0] x, input logic [2:0] n);
    in_valid = 1'b1;
    x_in     = x;
    n_terms  = n;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, then checks latency (cycle index, acceptance = cycle 0) and y.
  task automatic await_y(input string tag, input int exp_y, input int exp_lat);
    while (!out_valid && (cyc - acc_cyc) < 30) tick();
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_lat"}, cyc - acc_cyc + 1, exp_lat);
    chk({tag, "_y"}, int'(data_out), exp_y);
  endtask

  task automatic drain(input string tag, input int exp_y);
    out_ready = 1'b1;
    tick();
    chk({tag, "_drop"}, int'(out_valid), 0);
    chk({tag, "_keep"}, int'(data_out), exp_y);
    chk({tag, "_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    reset = 1'b1; coeff_we = 1'b0; coeff_addr = '0; coeff_data = '0;
    n_terms = '0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data", int'(data_out), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // c = {0.5, 1.0, 0, 0}, x = 0.5, N=1: 0.5 + 0.5 = 1.0
    wr(2'd0, 4'sd2);
    wr(2'd1, 4'sd4);
    send("t1", 4'sd4, 3'd1);
    await_y("t1", 32, 3);
    drain("t1", 32);

    // c2 = 1.0, N=2: T_2 = -0.5 -> y = 0.5
    wr(2'd2, 4'sd4);
    send("t2", 4'sd4, 3'd2);
    await_y("t2", 16, 4);
    drain("t2", 16);

    // all c = 1.0, x = -1.0: T alternates +1/-1 -> y = 0; N=7 clamps to 3
    wr(2'd0, 4'sd4);
    wr(2'd3, 4'sd4);
    send("t3", -4'sd8, 3'd3);
    await_y("t3", 0, 5);
    drain("t3", 0);
    send("t3c", -4'sd8, 3'd7);
    await_y("t3c", 0, 5);
    drain("t3c", 0);

    // x = 0.875: T = 8,7,4,-1 (1/8 units) -> 4*18 = 72
    send("t3d", 4'sd7, 3'd3);
    await_y("t3d", 72, 5);
    drain("t3d", 72);

    // x = 0.375: floor on negative product, T = 8,3,-6,-9 -> 4*(-4) = -16
    send("t3e", 4'sd3, 3'd3);
    await_y("t3e", -16, 5);
    drain("t3e", -16);

    // N = 0 -> y = c_0
    send("t3n0", 4'sd5, 3'd0);
    await_y("t3n0", 32, 2);
    drain("t3n0", 32);

    // Back-pressure: hold result 5 cycles while in_valid is offered
    out_ready = 1'b0;
    send("t4", 4'sd4, 3'd1);
    await_y("t4", 48, 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x_in = 4'sd0; n_terms = 3'd0;
      tick();
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_y", int'(data_out), 48);
      chk("t4_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_drop", int'(out_valid), 0);
    chk("t4_keep", int'(data_out), 48);
    chk("t4_idle", int'(in_ready), 1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    await_y("t4b", 32, 2);
    drain("t4b", 32);

    // Write during ITER is dropped (c1 stays 1.0)
    send("t5", 4'sd4, 3'd1);
    coeff_we = 1'b1; coeff_addr = 2'd1; coeff_data = 4'sd0;
    tick();
    coeff_we = 1'b0;
    await_y("t5", 48, 3);
    drain("t5", 48);

    // Write coinciding with acceptance: new c_0 = 0.5 is used
    coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 4'sd2;
    send("t5b", 4'sd4, 3'd1);
    coeff_we = 1'b0;
    await_y("t5b", 32, 3);
    drain("t5b", 32);

    // Reset at cycle 2 of an N=3 sample aborts it and clears coefficients
    send("t6", 4'sd4, 3'd3);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_in_ready", int'(in_ready), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_y", int'(data_out), 0);
    reset = 1'b0;
    #1;
    chk("t6_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t6_no_valid", seen, 0);
    send("t6b", 4'sd4, 3'd3);
    await_y("t6b", 0, 5);
    drain("t6b", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
